synapse_delay_sched: RTL and testbench



---
 rtl/synapse_delay_sched_pkg.sv | 16 +
 rtl/synapse_delay_sched_if.sv | 29 ++
 rtl/synapse_delay_ring.sv | 54 +++++
 rtl/synapse_delay_sched.sv | 102 ++++++++++
 tb/tb_synapse_delay_sched.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/synapse_delay_sched_pkg.sv
// Shared types and helpers for the synapse delay timing-wheel scheduler.
// slot_index maps a wheel pointer and a delay onto the slot that releases on tick ptr+d-1.
package synapse_sched_pkg;

   localparam int D_MAX_DEF = 8;
   localparam int DW_DEF    = $clog2(D_MAX_DEF + 1);

   typedef logic [DW_DEF-1:0] delay_t;

   function automatic int unsigned slot_index(input int unsigned ptr,
                                              input int unsigned d,
                                              input int unsigned d_max);
      return (ptr + d - 1) % d_max;
   endfunction

endpackage

// File: rtl/synapse_delay_sched_if.sv
// Spike-fabric / config / dendrite bundle around the delay scheduler.
// master drives ticks, spikes and delay writes; slave returns dendrite spikes and status.
interface synapse_delay_sched_if #(
   parameter int S     = 16,
   parameter int D_MAX = 8,
   parameter int DW    = $clog2(D_MAX + 1),
   parameter int AW    = $clog2(S)
);
   logic          tick;
   logic [S-1:0]  spike_in;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [DW-1:0] cfg_delay;
   logic [S-1:0]  spike_out;
   logic          spike_valid;
   logic          pending;
   logic          cfg_err;
   logic          merge_err;

   modport master (
      output tick, spike_in, cfg_we, cfg_addr, cfg_delay,
      input  spike_out, spike_valid, pending, cfg_err, merge_err
   );

   modport slave (
      input  tick, spike_in, cfg_we, cfg_addr, cfg_delay,
      output spike_out, spike_valid, pending, cfg_err, merge_err
   );
endinterface

// File: rtl/synapse_delay_ring.sv
// D_MAX x S timing wheel: head slot is read and cleared on advance, set_mask ORs future spikes in.
// Single-cycle update, no backpressure; collision flags a set onto an already-occupied bit.
module synapse_delay_ring #(
   parameter int S     = 16,
   parameter int D_MAX = 8,
   parameter int PW    = (D_MAX > 1) ? $clog2(D_MAX) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       advance,
   input  logic [D_MAX-1:0][S-1:0]    set_mask,
   output logic [PW-1:0]              ptr,
   output logic [S-1:0]               head,
   output logic                       collision,
   output logic                       pending
);

   logic [D_MAX-1:0][S-1:0] slot_q, slot_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic                    pending_q, pending_d;

   always_comb begin
      slot_d    = slot_q;
      ptr_d     = ptr_q;
      collision = 1'b0;
      if (advance) begin
         slot_d[ptr_q] = '0;
         ptr_d         = (ptr_q == PW'(D_MAX - 1)) ? '0 : ptr_q + 1'b1;
      end
      // set_mask never targets the head slot, so the clear above and these sets are disjoint
      for (int k = 0; k < D_MAX; k++) begin
         collision = collision | (|(slot_q[k] & set_mask[k]));
         slot_d[k] = slot_d[k] | set_mask[k];
      end
      pending_d = |slot_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q    <= '0;
         ptr_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         ptr_q     <= ptr_d;
         pending_q <= pending_d;
      end
   end

   assign ptr     = ptr_q;
   assign head    = slot_q[ptr_q];
   assign pending = pending_q;

endmodule

// File: rtl/synapse_delay_sched.sv
// Per-synapse programmable delay scheduler built on a shared timing wheel; delay 1 is same-tick pass-through.
// spike_out/spike_valid update the cycle after tick; accepts one tick per cycle, no backpressure.
module synapse_delay_sched
   import synapse_sched_pkg::*;
#(
   parameter int S     = 16,
   parameter int D_MAX = D_MAX_DEF,
   parameter int DW    = $clog2(D_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   synapse_delay_sched_if.slave bus
);

   localparam int PW = (D_MAX > 1) ? $clog2(D_MAX) : 1;

   logic [DW-1:0]           delay_q [S];
   logic [DW-1:0]           delay_d [S];
   logic [S-1:0]            spike_out_q, spike_out_d;
   logic                    spike_valid_q, spike_valid_d;
   logic                    cfg_err_q, cfg_err_d;
   logic                    merge_err_q, merge_err_d;

   logic [D_MAX-1:0][S-1:0] set_mask;
   logic [S-1:0]            mask_d1;
   logic [S-1:0]            head;
   logic [PW-1:0]           ptr;
   logic                    collision;
   logic                    ring_pending;
   logic                    cfg_ok;
   int unsigned             tgt;

   synapse_delay_ring #(
      .S     (S),
      .D_MAX (D_MAX),
      .PW    (PW)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .advance   (bus.tick),
      .set_mask  (set_mask),
      .ptr       (ptr),
      .head      (head),
      .collision (collision),
      .pending   (ring_pending)
   );

   // Scheduling reads delay_q, so a write landing with a tick only affects later ticks
   always_comb begin
      set_mask = '0;
      mask_d1  = '0;
      tgt      = 0;
      for (int j = 0; j < S; j++) begin
         mask_d1[j] = (delay_q[j] == DW'(1));
         if (bus.tick && bus.spike_in[j] && (delay_q[j] > DW'(1))) begin
            tgt                     = slot_index(32'(ptr), 32'(delay_q[j]), 32'(D_MAX));
            set_mask[tgt[PW-1:0]][j] = 1'b1;
         end
      end
   end

   always_comb begin
      cfg_ok = (bus.cfg_delay != '0) && (bus.cfg_delay <= DW'(D_MAX));
      for (int j = 0; j < S; j++) begin
         delay_d[j] = delay_q[j];
      end
      if (bus.cfg_we && cfg_ok) begin
         delay_d[bus.cfg_addr] = bus.cfg_delay;
      end
      cfg_err_d     = cfg_err_q | (bus.cfg_we & ~cfg_ok);
      merge_err_d   = merge_err_q | collision;
      spike_valid_d = bus.tick;
      spike_out_d   = bus.tick ? (head | (bus.spike_in & mask_d1)) : spike_out_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < S; j++) begin
            delay_q[j] <= DW'(1);
         end
         spike_out_q   <= '0;
         spike_valid_q <= 1'b0;
         cfg_err_q     <= 1'b0;
         merge_err_q   <= 1'b0;
      end else begin
         for (int j = 0; j < S; j++) begin
            delay_q[j] <= delay_d[j];
         end
         spike_out_q   <= spike_out_d;
         spike_valid_q <= spike_valid_d;
         cfg_err_q     <= cfg_err_d;
         merge_err_q   <= merge_err_d;
      end
   end

   assign bus.spike_out   = spike_out_q;
   assign bus.spike_valid = spike_valid_q;
   assign bus.pending     = ring_pending;
   assign bus.cfg_err     = cfg_err_q;
   assign bus.merge_err   = merge_err_q;

endmodule

// File: tb/tb_synapse_delay_sched.sv
// Directed vector table plus a mid-flight reset sequence for synapse_delay_sched.
module tb_synapse_delay_sched;
   import synapse_sched_pkg::*;

   localparam int S     = 16;
   localparam int D_MAX = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   synapse_delay_sched_if #(.S(S), .D_MAX(D_MAX)) bus ();

   synapse_delay_sched #(.S(S), .D_MAX(D_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        tk;
      logic [15:0] sp;
      logic        we;
      logic [3:0]  ad;
      delay_t      dl;
      logic [15:0] eo;
      logic        ev;
      logic        ep;
      logic        ece;
      logic        eme;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic tk, input logic [15:0] sp, input logic we,
                               input logic [3:0] ad, input delay_t dl, input logic [15:0] eo,
                               input logic ep, input logic ece, input logic eme);
      vec_t v;
      v.tk = tk; v.sp = sp; v.we = we; v.ad = ad; v.dl = dl;
      v.eo = eo; v.ev = tk; v.ep = ep; v.ece = ece; v.eme = eme;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] eo, input logic ev,
                            input logic ep, input logic ece, input logic eme);
      check({tag, ".spike_out"},   bus.spike_out, eo);
      check({tag, ".spike_valid"}, 16'(bus.spike_valid), 16'(ev));
      check({tag, ".pending"},     16'(bus.pending), 16'(ep));
      check({tag, ".cfg_err"},     16'(bus.cfg_err), 16'(ece));
      check({tag, ".merge_err"},   16'(bus.merge_err), 16'(eme));
   endtask

   task automatic apply(input logic tk, input logic [15:0] sp, input logic we,
                        input logic [3:0] ad, input delay_t dl);
      bus.tick      = tk;
      bus.spike_in  = sp;
      bus.cfg_we    = we;
      bus.cfg_addr  = ad;
      bus.cfg_delay = dl;
      @(posedge clk);
      #1;
      bus.tick      = 1'b0;
      bus.spike_in  = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_delay = '0;
   endtask

   initial begin
      // pass-through with all delays = 1
      vecs.push_back(mk(1, 16'h00A5, 0, 0, 0, 16'h00A5, 0, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h00A5, 0, 0, 0));
      // delay[3]=4, fired at ptr=1 -> slot 4, released on the 3rd following tick
      vecs.push_back(mk(0, 16'h0000, 1, 3, 4, 16'h00A5, 0, 0, 0));
      vecs.push_back(mk(1, 16'h0008, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0008, 0, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
      // delay[0]=8 fired at ptr=6 -> wraps to slot 5, out 7 ticks later
      vecs.push_back(mk(0, 16'h0000, 1, 0, 8, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0001, 0, 0, 0));
      // illegal writes to synapse 5: table must still hold 1
      vecs.push_back(mk(0, 16'h0000, 1, 5, 0, 16'h0001, 0, 1, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 5, 9, 16'h0001, 0, 1, 0));
      vecs.push_back(mk(1, 16'h0020, 0, 0, 0, 16'h0020, 0, 1, 0));
      // write coinciding with tick: that tick still sees delay 1
      vecs.push_back(mk(1, 16'h0020, 1, 5, 3, 16'h0020, 0, 1, 0));
      vecs.push_back(mk(1, 16'h0020, 0, 0, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0020, 0, 1, 0));
      // merge: delay 5 at ptr=3 and delay 3 at ptr=5 both land in slot 7
      vecs.push_back(mk(0, 16'h0000, 1, 2, 5, 16'h0020, 0, 1, 0));
      vecs.push_back(mk(1, 16'h0004, 0, 0, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(0, 16'h0000, 1, 2, 3, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(1, 16'h0004, 0, 0, 0, 16'h0000, 1, 1, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0004, 0, 1, 1));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0004, 0, 1, 1));

      reset         = 1'b1;
      bus.tick      = 1'b0;
      bus.spike_in  = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_delay = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 16'h0000, 0, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].tk, vecs[i].sp, vecs[i].we, vecs[i].ad, vecs[i].dl);
         check_all($sformatf("v%0d", i), vecs[i].eo, vecs[i].ev, vecs[i].ep,
                   vecs[i].ece, vecs[i].eme);
      end

      // three spikes in flight (delays 8, 3, 4 at ptr=0), then reset
      apply(1, 16'h000D, 0, 0, 0);
      check_all("inflight", 16'h0000, 1, 1, 1, 1);
      reset = 1'b1;
      apply(0, 16'h0000, 0, 0, 0);
      reset = 1'b0;
      check_all("midreset", 16'h0000, 0, 0, 0, 0);
      for (int t = 0; t < D_MAX; t++) begin
         apply(1, 16'h0000, 0, 0, 0);
         check_all($sformatf("drain%0d", t), 16'h0000, 1, 0, 0, 0);
      end
      // delay table back to 1 after reset
      apply(1, 16'h0008, 0, 0, 0);
      check_all("post_reset_d1", 16'h0008, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
